// File: rtl/hsst_tx_framer.sv
// Purpose : drains the TX FIFO read port and frames words for the HSST lane as
//           SOF, payload (1..MAX_LEN words), CRC-16-CCITT, EOF, then an idle gap.
// Latency : tx_data/tx_charisk are registered; the word reflects the previous cycle's state.
// Backpr. : none. The lane takes one word per rd_clk; FIFO underrun ends the frame early.
//
// Ports:
//   rd_clk, rd_rst            TX user clock, async active-high reset
//   enable                    allow new frames to start (sampled in IDLE only)
//   fifo_rd_empty/data/en     FIFO read port; data valid one cycle after accepted read
//   tx_data, tx_charisk       registered lane word and per-byte K flags
//   busy                      high from SOF through EOF
//   frame_cnt                 completed frames, wraps
module hsst_tx_framer #(
  parameter int unsigned MAX_LEN   = 256,
  parameter int unsigned IDLE_MIN  = 8,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF,
  parameter logic [15:0] IDLE_WORD = 16'h50BC,
  parameter logic [15:0] SOF_WORD  = 16'h00FB,
  parameter logic [15:0] EOF_WORD  = 16'h00FD
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        enable,
  input  logic        fifo_rd_empty,
  input  logic [15:0] fifo_rd_data,
  output logic        fifo_rd_en,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_charisk,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_EOF     = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  localparam logic [8:0] MAX_LEN_C = 9'(MAX_LEN);
  localparam logic [7:0] GAP_C     = 8'(IDLE_MIN);

  state_t      state_q;
  logic [8:0]  cnt_q;
  logic [7:0]  gap_q;
  logic [15:0] crc_q;
  logic [15:0] tx_data_q;
  logic [1:0]  tx_charisk_q;
  logic [15:0] frame_cnt_q;

  // One 16-bit word through CRC-16-CCITT (poly 0x1021), MSB first. XOR-ing the
  // whole word in up front is equivalent to bit-serial feedback when the data
  // width equals the CRC width.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [15:0] data);
    logic [15:0] c;
    c = crc ^ data;
    for (int i = 0; i < 16; i++) begin
      if (c[15]) c = (c << 1) ^ 16'h1021;
      else       c = c << 1;
    end
    return c;
  endfunction

  // In SOF the FIFO is known non-empty, but gating with empty keeps the read
  // strobe clean even if that guarantee is ever broken upstream.
  always_comb begin
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_SOF:     fifo_rd_en = ~fifo_rd_empty;
      ST_PAYLOAD: fifo_rd_en = ~fifo_rd_empty && (cnt_q < MAX_LEN_C);
      default:    fifo_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      crc_q        <= CRC_INIT;
      tx_data_q    <= IDLE_WORD;
      tx_charisk_q <= 2'b01;
      frame_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_data_q    <= IDLE_WORD;
          tx_charisk_q <= 2'b01;
          if (enable && !fifo_rd_empty) state_q <= ST_SOF;
        end
        ST_SOF: begin
          // First read is issued here; its data shows up in PAYLOAD.
          tx_data_q    <= SOF_WORD;
          tx_charisk_q <= 2'b01;
          crc_q        <= CRC_INIT;
          cnt_q        <= 9'd1;
          state_q      <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          // Payload is sent as data characters regardless of its byte values.
          tx_data_q    <= fifo_rd_data;
          tx_charisk_q <= 2'b00;
          crc_q        <= crc16_step(crc_q, fifo_rd_data);
          if (fifo_rd_en) cnt_q   <= cnt_q + 9'd1;
          else            state_q <= ST_CRC;
        end
        ST_CRC: begin
          tx_data_q    <= crc_q;
          tx_charisk_q <= 2'b00;
          state_q      <= ST_EOF;
        end
        ST_EOF: begin
          tx_data_q    <= EOF_WORD;
          tx_charisk_q <= 2'b01;
          frame_cnt_q  <= frame_cnt_q + 16'd1;
          gap_q        <= GAP_C;
          state_q      <= ST_GAP;
        end
        ST_GAP: begin
          // IDLE_MIN gap cycles plus the IDLE cycle that launches SOF give
          // IDLE_MIN+1 idle words between EOF and the next SOF.
          tx_data_q    <= IDLE_WORD;
          tx_charisk_q <= 2'b01;
          gap_q        <= gap_q - 8'd1;
          if (gap_q <= 8'd1) state_q <= ST_IDLE;
        end
        default: begin
          tx_data_q    <= IDLE_WORD;
          tx_charisk_q <= 2'b01;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_charisk = tx_charisk_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q == ST_SOF) || (state_q == ST_PAYLOAD) ||
                      (state_q == ST_CRC) || (state_q == ST_EOF);

endmodule
